// File: rtl/gem_rom_arbiter.sv
// Round-robin arbiter that lets the six string renderers share one pipelined gem sprite ROM.
// Issues at most one read per cycle and returns each read's data tagged with the requester index.
module gem_rom_arbiter #(
    parameter int NUM_REQ = 6,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 12,
    parameter int ROM_LAT = 2,
    parameter int ID_W    = 3
) (
    input  logic                      clk65,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic                      hold,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      rom_en,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      busy
);

    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               rom_en_q, rom_en_d;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;

    logic [NUM_REQ-1:0] elig;
    logic               win_valid;
    logic [ID_W-1:0]    win_idx;
    logic               fire;

    // Stage s holds the read issued s cycles ago; the last stage lines up with valid rom_data.
    logic [ROM_LAT:0]   stg_vld_q;
    logic [ID_W-1:0]    stg_id_q [ROM_LAT+1];

    logic               rsp_valid_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic [DATA_W-1:0]  rsp_data_q;

    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return ID_W'(s);
    endfunction

    // A requester granted this cycle still shows its old req, so it is masked out.
    assign elig = req & ~gnt_q;

    // Scan from the far end so the last hit is the one closest to the pointer.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            if (elig[wrap_idx(ptr_q, off)]) begin
                win_valid = 1'b1;
                win_idx   = wrap_idx(ptr_q, off);
            end
        end
    end

    assign fire = win_valid & ~hold;

    always_comb begin
        gnt_d      = '0;
        rom_en_d   = 1'b0;
        rom_addr_d = rom_addr_q;
        ptr_d      = ptr_q;
        if (fire) begin
            gnt_d      = NUM_REQ'(1) << win_idx;
            rom_en_d   = 1'b1;
            rom_addr_d = req_addr[win_idx*ADDR_W +: ADDR_W];
            ptr_d      = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge clk65 or posedge rst) begin
        if (rst) begin
            gnt_q      <= '0;
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            ptr_q      <= '0;
        end else begin
            gnt_q      <= gnt_d;
            rom_en_q   <= rom_en_d;
            rom_addr_q <= rom_addr_d;
            ptr_q      <= ptr_d;
        end
    end

    always_ff @(posedge clk65 or posedge rst) begin
        if (rst) begin
            for (int s = 0; s <= ROM_LAT; s++) begin
                stg_vld_q[s] <= 1'b0;
                stg_id_q[s]  <= '0;
            end
        end else begin
            stg_vld_q[0] <= fire;
            stg_id_q[0]  <= win_idx;
            for (int s = 1; s <= ROM_LAT; s++) begin
                stg_vld_q[s] <= stg_vld_q[s-1];
                stg_id_q[s]  <= stg_id_q[s-1];
            end
        end
    end

    always_ff @(posedge clk65 or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= stg_vld_q[ROM_LAT];
            if (stg_vld_q[ROM_LAT]) begin
                rsp_id_q   <= stg_id_q[ROM_LAT];
                rsp_data_q <= rom_data;
            end
        end
    end

    assign gnt       = gnt_q;
    assign rom_en    = rom_en_q;
    assign rom_addr  = rom_addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (|gnt_q) | (|stg_vld_q) | rsp_valid_q;

endmodule

// File: tb/tb_gem_rom_arbiter.sv
// Directed bench for gem_rom_arbiter with a two-cycle pipelined ROM model.
// Each scenario task drives stimulus and compares against hand-derived values.
module tb_gem_rom_arbiter;

    logic        clk65;
    logic        rst;
    logic [5:0]  req;
    logic [71:0] req_addr;
    logic        hold;
    logic [5:0]  gnt;
    logic        rom_en;
    logic [11:0] rom_addr;
    logic [11:0] rom_data;
    logic        rsp_valid;
    logic [2:0]  rsp_id;
    logic [11:0] rsp_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    gem_rom_arbiter dut (
        .clk65     (clk65),
        .rst       (rst),
        .req       (req),
        .req_addr  (req_addr),
        .hold      (hold),
        .gnt       (gnt),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    initial clk65 = 1'b0;
    always #5 clk65 = ~clk65;

    function automatic logic [11:0] rom_fn(input logic [11:0] a);
        if (a == 12'h1A5) return 12'hF0F;
        return a * 12'd7 + 12'd3;
    endfunction

    // Pipelined ROM: data for an enabled address is on rom_data two cycles later.
    logic [11:0] rom_p1, rom_p2;
    always @(posedge clk65) begin
        rom_p1 <= rom_en ? rom_fn(rom_addr) : 12'hBAD;
        rom_p2 <= rom_p1;
    end
    assign rom_data = rom_p2;

    task automatic tick();
        @(posedge clk65);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [11:0] a);
        req_addr[i*12 +: 12] = a;
    endtask

    task automatic do_reset();
        req  = '0;
        hold = 1'b0;
        rst  = 1'b1;
        tick();
        tick();
        rst  = 1'b0;
    endtask

    task automatic test_reset();
        logic [35:0] outs;
        rst = 1'b1; req = '0; hold = 1'b0; req_addr = '0;
        tick();
        outs = {gnt, rom_en, rom_addr, rsp_valid, rsp_id, rsp_data, busy};
        checks++;
        if (outs !== 36'd0) begin
            errors++;
            $display("FAIL reset_state: outputs=%h expected=0", outs);
        end
        rst = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick();
            outs = {gnt, rom_en, rom_addr, rsp_valid, rsp_id, rsp_data, busy};
            checks++;
            if (outs !== 36'd0) begin
                errors++;
                $display("FAIL idle_cycle%0d: outputs=%h expected=0", n, outs);
            end
        end
        $display("test_reset done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_single();
        do_reset();
        set_addr(2, 12'h1A5);
        req = 6'b000100;
        tick();  // cycle E+1
        checks++;
        if ({gnt, rom_en, rom_addr, busy} !== {6'b000100, 1'b1, 12'h1A5, 1'b1}) begin
            errors++;
            $display("FAIL single_grant: gnt=%b en=%b addr=%h busy=%b expected 000100 1 1a5 1",
                     gnt, rom_en, rom_addr, busy);
        end
        req = '0;
        for (int n = 2; n <= 3; n++) begin
            tick();
            checks++;
            if ({gnt, rom_en, rom_addr, rsp_valid, busy} !== {6'b0, 1'b0, 12'h1A5, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL single_wait_E+%0d: gnt=%b en=%b addr=%h rv=%b busy=%b expected 0 0 1a5 0 1",
                         n, gnt, rom_en, rom_addr, rsp_valid, busy);
            end
        end
        tick();  // cycle E+4
        checks++;
        if ({rsp_valid, rsp_id, rsp_data, busy} !== {1'b1, 3'd2, 12'hF0F, 1'b1}) begin
            errors++;
            $display("FAIL single_rsp: rv=%b id=%0d data=%h busy=%b expected 1 2 f0f 1",
                     rsp_valid, rsp_id, rsp_data, busy);
        end
        tick();
        checks++;
        if ({rsp_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL single_idle: rv=%b busy=%b expected 0 0", rsp_valid, busy);
        end
        $display("test_single done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_all_six();
        int seq [8] = '{0, 1, 2, 3, 4, 5, 0, 1};
        logic [5:0]  exp_g;
        logic [11:0] a;
        do_reset();
        for (int i = 0; i < 6; i++) set_addr(i, 12'h100 + 12'(i));
        req = 6'b111111;
        for (int n = 1; n <= 11; n++) begin
            tick();
            exp_g = (n <= 8) ? (6'b000001 << seq[n-1]) : 6'b0;
            checks++;
            if (gnt !== exp_g) begin
                errors++;
                $display("FAIL all6_gnt_c%0d: gnt=%b expected=%b", n, gnt, exp_g);
            end
            if (n <= 8) begin
                checks++;
                if (rom_addr !== 12'h100 + 12'(seq[n-1])) begin
                    errors++;
                    $display("FAIL all6_addr_c%0d: addr=%h expected=%h", n, rom_addr, 12'h100 + 12'(seq[n-1]));
                end
            end
            if (n >= 4) begin
                a = 12'h100 + 12'(seq[n-4]);
                checks++;
                if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 3'(seq[n-4]), rom_fn(a)}) begin
                    errors++;
                    $display("FAIL all6_rsp_c%0d: rv=%b id=%0d data=%h expected 1 %0d %h",
                             n, rsp_valid, rsp_id, rsp_data, seq[n-4], rom_fn(a));
                end
            end
            req = (n < 8) ? ~gnt : 6'b0;
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL all6_drain: busy=%b expected=0", busy);
        end
        $display("test_all_six done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_fairness();
        logic [5:0] exp_g;
        do_reset();
        set_addr(0, 12'h010);
        set_addr(5, 12'h050);
        req = 6'b100001;
        for (int n = 1; n <= 8; n++) begin
            tick();
            exp_g = (n % 2 == 1) ? 6'b000001 : 6'b100000;
            checks++;
            if (gnt !== exp_g) begin
                errors++;
                $display("FAIL fair_c%0d: gnt=%b expected=%b", n, gnt, exp_g);
            end
        end
        req = '0;
        for (int n = 0; n < 4; n++) tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL fair_drain: busy=%b expected=0", busy);
        end
        $display("test_fairness done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_hold();
        do_reset();
        set_addr(0, 12'h222);
        set_addr(3, 12'h333);
        req = 6'b000001;
        tick();
        checks++;
        if (gnt !== 6'b000001) begin
            errors++;
            $display("FAIL hold_first_gnt: gnt=%b expected=000001", gnt);
        end
        // hold rises together with req[3]; hold must win
        req  = 6'b001000;
        hold = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            tick();
            checks++;
            if ({gnt, rom_en} !== 7'b0) begin
                errors++;
                $display("FAIL hold_nogrant_c%0d: gnt=%b en=%b expected 0 0", n, gnt, rom_en);
            end
            checks++;
            if (n == 3) begin
                if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 3'd0, rom_fn(12'h222)}) begin
                    errors++;
                    $display("FAIL hold_inflight_rsp: rv=%b id=%0d data=%h expected 1 0 %h",
                             rsp_valid, rsp_id, rsp_data, rom_fn(12'h222));
                end
            end else if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL hold_rv_c%0d: rv=%b expected=0", n, rsp_valid);
            end
        end
        hold = 1'b0;
        tick();  // cycle H+1
        checks++;
        if ({gnt, rom_en, rom_addr} !== {6'b001000, 1'b1, 12'h333}) begin
            errors++;
            $display("FAIL hold_release_gnt: gnt=%b en=%b addr=%h expected 001000 1 333", gnt, rom_en, rom_addr);
        end
        req = '0;
        tick();
        tick();
        tick();
        checks++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 3'd3, rom_fn(12'h333)}) begin
            errors++;
            $display("FAIL hold_release_rsp: rv=%b id=%0d data=%h expected 1 3 %h",
                     rsp_valid, rsp_id, rsp_data, rom_fn(12'h333));
        end
        $display("test_hold done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_reset_mid();
        logic [35:0] outs;
        do_reset();
        set_addr(1, 12'h055);
        req = 6'b000010;
        tick();
        checks++;
        if (gnt !== 6'b000010) begin
            errors++;
            $display("FAIL midrst_gnt: gnt=%b expected=000010", gnt);
        end
        req = '0;
        tick();
        rst = 1'b1;
        #1;
        outs = {gnt, rom_en, rom_addr, rsp_valid, rsp_id, rsp_data, busy};
        checks++;
        if (outs !== 36'd0) begin
            errors++;
            $display("FAIL midrst_clear: outputs=%h expected=0", outs);
        end
        tick();
        tick();
        rst = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            tick();
            checks++;
            if ({rsp_valid, busy} !== 2'b00) begin
                errors++;
                $display("FAIL midrst_no_rsp_c%0d: rv=%b busy=%b expected 0 0", n, rsp_valid, busy);
            end
        end
        set_addr(0, 12'h0A0);
        set_addr(4, 12'h0E0);
        req = 6'b010001;
        tick();
        checks++;
        if (gnt !== 6'b000001) begin
            errors++;
            $display("FAIL midrst_ptr0: gnt=%b expected=000001", gnt);
        end
        tick();
        checks++;
        if (gnt !== 6'b010000) begin
            errors++;
            $display("FAIL midrst_next: gnt=%b expected=010000", gnt);
        end
        req = '0;
        for (int n = 0; n < 4; n++) tick();
        $display("test_reset_mid done: checks=%0d errors=%0d", checks, errors);
    endtask

    initial begin
        rst      = 1'b1;
        req      = '0;
        req_addr = '0;
        hold     = 1'b0;
        test_reset();
        test_single();
        test_all_six();
        test_fairness();
        test_hold();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
